// File: rtl/frv_mem_adapter_buf.sv
// Core-to-memory adapter with credit-limited response FIFO.
// Define FRV_MEM_ADAPTER_BYPASS_EN to let a response skip the empty FIFO.
module frv_mem_adapter_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_req,
  input  logic                  mem_wen,
  input  logic [DATA_W/8-1:0]   mem_strb,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_gnt,
  output logic                  mem_recv,
  input  logic                  mem_ack,
  output logic                  mem_error,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  out_mem_req,
  input  logic                  out_mem_gnt,
  output logic [ADDR_W-1:0]     out_mem_addr,
  output logic [DATA_W-1:0]     out_mem_wdata,
  output logic [DATA_W/8-1:0]   out_mem_strb,
  output logic                  out_mem_we,
  input  logic [DATA_W-1:0]     out_mem_rdata,
  input  logic                  out_mem_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic              r_inflight;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic              r_err  [DEPTH];

  logic [CW:0] w_used;
  logic        w_credit_ok;
  logic        w_nempty;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Credits use registered state only, so a pop frees space next cycle.
  assign w_used      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_credit_ok = w_used < DEPTH_C;

  assign out_mem_req   = rst_ni & mem_req & w_credit_ok;
  assign mem_gnt       = out_mem_req & out_mem_gnt;
  assign out_mem_addr  = mem_addr;
  assign out_mem_wdata = mem_wdata;
  assign out_mem_strb  = mem_strb;
  assign out_mem_we    = mem_wen;

  assign w_nempty = r_count != '0;

`ifdef FRV_MEM_ADAPTER_BYPASS_EN
  assign w_bypass = r_inflight & ~w_nempty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push   = r_inflight & ~(w_bypass & mem_ack);
  assign w_pop    = w_nempty & mem_ack;
  assign mem_recv = w_nempty | w_bypass;

  always_comb begin
    mem_rdata = '0;
    mem_error = 1'b0;
    unique case (1'b1)
      w_nempty: begin
        mem_rdata = r_data[r_rptr];
        mem_error = r_err[r_rptr];
      end
      w_bypass: begin
        mem_rdata = out_mem_rdata;
        mem_error = out_mem_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= mem_gnt;
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_wptr] <= out_mem_rdata;
      r_err[r_wptr]  <= out_mem_err;
    end
  end

endmodule

// File: tb/tb_frv_mem_adapter_buf.sv
// Scoreboard bench for frv_mem_adapter_buf with a word-array memory model.
// Works with or without FRV_MEM_ADAPTER_BYPASS_EN.
module tb_frv_mem_adapter_buf;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int D  = 2;
`ifdef FRV_MEM_ADAPTER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          mem_req, mem_wen, mem_ack;
  logic [DW/8-1:0] mem_strb;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt, mem_recv, mem_error;
  logic          out_mem_req, out_mem_gnt, out_mem_we, out_mem_err;
  logic [AW-1:0] out_mem_addr;
  logic [DW-1:0] out_mem_wdata, out_mem_rdata;
  logic [DW/8-1:0] out_mem_strb;

  always #5 clk = ~clk;

  frv_mem_adapter_buf #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error),
    .mem_rdata(mem_rdata),
    .out_mem_req(out_mem_req), .out_mem_gnt(out_mem_gnt),
    .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
    .out_mem_strb(out_mem_strb), .out_mem_we(out_mem_we),
    .out_mem_rdata(out_mem_rdata), .out_mem_err(out_mem_err)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  resp_t       exp_q[$];
  logic [31:0] ref_mem[8];
  logic [31:0] stub_mem[8];
  logic        pend_v = 1'b0;
  logic [31:0] pend_d;
  logic        pend_e;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m = 0;
    for (int b = 0; b < 4; b++)
      if (s[b]) m = m + (32'hFF << (8 * b));
    return m;
  endfunction

  // Scoreboard, reference model and memory responder
  always @(negedge clk) begin : mon
    resp_t       r;
    resp_t       e;
    logic [2:0]  idx;
    logic [31:0] m;
    if (!rst_ni) begin
      exp_q.delete();
      pend_v = 1'b0;
    end else begin
      if (mem_recv && mem_ack) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_resp: got %0h expected none",
                   {mem_error, mem_rdata});
        end else begin
          r = exp_q.pop_front();
          chk("resp", {31'b0, mem_error, mem_rdata}, {31'b0, r.err, r.data});
        end
      end
      idx = mem_addr[4:2];
      if (mem_gnt) begin
        e.err = (idx == 3'd7);
        if (mem_wen) begin
          m = strb_mask(mem_strb);
          ref_mem[idx] = (ref_mem[idx] & ~m) | (mem_wdata & m);
          e.data = 32'h0;
        end else begin
          e.data = ref_mem[idx];
        end
        exp_q.push_back(e);
      end
      pend_v = out_mem_req && out_mem_gnt;
      if (pend_v) begin
        idx = out_mem_addr[4:2];
        pend_e = (idx == 3'd7);
        if (out_mem_we) begin
          for (int b = 0; b < 4; b++)
            if (out_mem_strb[b])
              stub_mem[idx][8*b +: 8] = out_mem_wdata[8*b +: 8];
          pend_d = 32'h0;
        end else begin
          pend_d = stub_mem[idx];
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (pend_v) begin
      out_mem_rdata = pend_d;
      out_mem_err   = pend_e;
    end else begin
      out_mem_rdata = $urandom;
      out_mem_err   = 1'($urandom);
    end
  end

  task automatic drv(input logic req, input logic wen, input logic [3:0] s,
                     input logic [31:0] wd, input logic [2:0] idx,
                     input logic og, input logic ack);
    @(posedge clk);
    #1;
    mem_req     = req;
    mem_wen     = wen;
    mem_strb    = s;
    mem_wdata   = wd;
    mem_addr    = {27'b0, idx, 2'b00};
    out_mem_gnt = og;
    mem_ack     = ack;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 4'h0, 32'h0, 3'd0, 1'b1, 1'b1);
  endtask

  int g;

  initial begin
    for (int i = 0; i < 8; i++) begin
      ref_mem[i]  = 32'h0101_0101 * i;
      stub_mem[i] = 32'h0101_0101 * i;
    end
    rst_ni = 1'b0;
    mem_req = 1'b1; mem_wen = 1'b0; mem_strb = 4'hF;
    mem_wdata = '0; mem_addr = '0; mem_ack = 1'b1;
    out_mem_gnt = 1'b1; out_mem_rdata = '0; out_mem_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_recv", mem_recv, 0);
    chk("reset_gnt", mem_gnt, 0);
    chk("reset_oreq", out_mem_req, 0);
    chk("reset_rdata", mem_rdata, 0);
    chk("reset_err", mem_error, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    mem_req = 1'b0;
    idle(2);

    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0, 4'hF, 32'h0, 3'd0, 1'b0, 1'b1);
      @(negedge clk);
      chk("stall_oreq", out_mem_req, 1);
      chk("stall_gnt", mem_gnt, 0);
    end
    drv(1'b1, 1'b0, 4'hF, 32'h0, 3'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("stall_grant", mem_gnt, 1);
    idle(4);

    g = 0;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b0, 4'hF, 32'h0, 3'd1, 1'b1, 1'b0);
      @(negedge clk);
      if (mem_gnt) g++;
    end
    chk("bp_grants", g, 2);
    drv(1'b1, 1'b0, 4'hF, 32'h0, 3'd1, 1'b1, 1'b1);
    @(negedge clk);
    chk("bp_gnt_on_ack", mem_gnt, 0);
    drv(1'b1, 1'b0, 4'hF, 32'h0, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_gnt_after_ack", mem_gnt, 1);
    drv(1'b1, 1'b0, 4'hF, 32'h0, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_gnt_refull", mem_gnt, 0);
    idle(6);

    g = 0;
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, 1'b0, 4'hF, 32'h0, 3'(i), 1'b1, 1'b1);
      @(negedge clk);
      if (mem_gnt) g++;
    end
    chk("b2b_grants", g, BYP ? 6 : 4);
    idle(4);

    drv(1'b1, 1'b1, 4'hF, 32'hDEAD, 3'd7, 1'b1, 1'b1);
    idle(4);
    drv(1'b1, 1'b0, 4'hF, 32'h0, 3'd7, 1'b1, 1'b0);
    @(negedge clk);
    chk("err_gnt", mem_gnt, 1);
    drv(1'b0, 1'b0, 4'h0, 32'h0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("err_recv_early", mem_recv, BYP);
    drv(1'b0, 1'b0, 4'h0, 32'h0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("err_recv", mem_recv, 1);
    chk("err_flag", mem_error, 1);
    chk("err_rdata", mem_rdata, 32'hDEAD);
    idle(4);

    drv(1'b1, 1'b0, 4'hF, 32'h0, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_g1", mem_gnt, 1);
    drv(1'b1, 1'b0, 4'hF, 32'h0, 3'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_g2", mem_gnt, 1);
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("rst_recv", mem_recv, 0);
    chk("rst_gnt", mem_gnt, 0);
    chk("rst_oreq", out_mem_req, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_regrant", mem_gnt, 1);
    idle(4);

    repeat (400)
      drv(($urandom % 4) != 0, 1'($urandom), 4'($urandom), $urandom,
          3'($urandom), ($urandom % 4) != 0, ($urandom % 3) != 0);

    idle(20);
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_recv", mem_recv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
